// File: rtl/display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : display_arbiter
//  Description : Three-way round-robin arbiter that hands a shared 4-digit
//                BCD display to one requester at a time. Each owner keeps
//                the display for at least HOLD_CYCLES clocks. A short gap in
//                its request keeps the last digits on screen (linger).
//  Revision    : 1.0 - initial release
// ============================================================================
module display_arbiter #(
    parameter int HOLD_CYCLES = 200_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [2:0]  grant,
    output logic [3:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic        blank
);

    // Hold counter width: it only ever counts up to HOLD_CYCLES-1.
    localparam int              c_cnt_w   = $clog2(HOLD_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SERVE  = 2'd1,
        ST_LINGER = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t               state_q,  state_d;
    logic [1:0]           g_q,      g_d;
    logic [1:0]           ptr_q,    ptr_d;
    logic [c_cnt_w-1:0]   cnt_q,    cnt_d;
    logic [2:0]           grant_q,  grant_d;
    logic [15:0]          digits_q, digits_d;
    logic                 blank_q,  blank_d;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0]          w_data_g;
    logic                 w_req_g;
    logic                 w_hold_done;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic [2:0]           w_others;
    logic [2:0]           w_pick_idle;   // {found, index}
    logic [2:0]           w_pick_done;   // {found, index}

    // Successor index with 2 wrapping back to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] i);
        case (i)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // First asserted bit of r, scanning from start and wrapping 2->0.
    // Returns {found, index}.
    function automatic logic [2:0] rr_search(input logic [2:0] r,
                                             input logic [1:0] start);
        logic [1:0] i0;
        logic [1:0] i1;
        logic [1:0] i2;
        i0 = start;
        i1 = next_idx(i0);
        i2 = next_idx(i1);
        if ((r & onehot(i0)) != 3'b000) return {1'b1, i0};
        if ((r & onehot(i1)) != 3'b000) return {1'b1, i1};
        if ((r & onehot(i2)) != 3'b000) return {1'b1, i2};
        return 3'b000;
    endfunction

    // Owner-related decode: selected data, owner request, hold status and
    // the two arbitration searches (fresh from ptr, or rotation past owner).
    always_comb begin
        case (g_q)
            2'd0:    w_data_g = data0;
            2'd1:    w_data_g = data1;
            default: w_data_g = data2;
        endcase
        w_req_g     = |(req & onehot(g_q));
        w_hold_done = (cnt_q == c_cnt_max);
        w_cnt_inc   = w_hold_done ? cnt_q : cnt_q + c_cnt_w'(1);
        w_others    = req & ~onehot(g_q);
        w_pick_idle = rr_search(req, ptr_q);
        w_pick_done = rr_search(w_others, next_idx(g_q));
    end

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        digits_d = digits_q;
        blank_d  = blank_q;

        case (state_q)
            ST_IDLE: begin
                grant_d = 3'b000;
                blank_d = 1'b1;
                if (w_pick_idle[2]) begin
                    state_d = ST_SERVE;
                    g_d     = w_pick_idle[1:0];
                    ptr_d   = next_idx(w_pick_idle[1:0]);
                    cnt_d   = '0;
                    grant_d = onehot(w_pick_idle[1:0]);
                    blank_d = 1'b0;
                end
            end

            ST_SERVE, ST_LINGER: begin
                cnt_d   = w_cnt_inc;
                blank_d = 1'b0;
                // Live digits only while serving; lingering freezes them.
                if (state_q == ST_SERVE) begin
                    digits_d = w_data_g;
                end
                if (w_hold_done) begin
                    if (w_pick_done[2]) begin
                        // Hand over directly, no idle cycle between owners.
                        state_d = ST_SERVE;
                        g_d     = w_pick_done[1:0];
                        ptr_d   = next_idx(w_pick_done[1:0]);
                        cnt_d   = '0;
                        grant_d = onehot(w_pick_done[1:0]);
                    end else if (w_req_g) begin
                        state_d = ST_SERVE;
                    end else begin
                        state_d = ST_IDLE;
                        grant_d = 3'b000;
                        blank_d = 1'b1;
                    end
                end else if (w_req_g) begin
                    state_d = ST_SERVE;
                end else begin
                    state_d = ST_LINGER;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = 3'b000;
                blank_d = 1'b1;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            g_q      <= 2'd0;
            ptr_q    <= 2'd0;
            cnt_q    <= '0;
            grant_q  <= 3'b000;
            digits_q <= 16'h0000;
            blank_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            digits_q <= digits_d;
            blank_q  <= blank_d;
        end
    end

    assign grant     = grant_q;
    assign thousands = digits_q[15:12];
    assign hundreds  = digits_q[11:8];
    assign tens      = digits_q[7:4];
    assign ones      = digits_q[3:0];
    assign blank     = blank_q;

endmodule
`default_nettype wire

// File: tb/tb_display_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_arbiter
//  Description : Self-checking bench for display_arbiter with HOLD_CYCLES=4.
//                An ownership-level model (owner, age, live flag) predicts
//                every output each cycle; directed scenarios add literal
//                expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_arbiter;

    localparam int HOLD = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req   = 3'b000;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [15:0] data2 = 16'h0000;
    logic [2:0]  grant;
    logic [3:0]  thousands;
    logic [3:0]  hundreds;
    logic [3:0]  tens;
    logic [3:0]  ones;
    logic        blank;

    int vectors     = 0;
    int miscompares = 0;

    display_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data0     (data0),
        .data1     (data1),
        .data2     (data2),
        .grant     (grant),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .blank     (blank)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Ownership model
    // ------------------------------------------------------------------------
    int          m_owner  = -1;     // -1 means nobody owns the display
    int          m_age    = 0;      // cycles since grant, saturating
    int          m_ptr    = 0;
    bit          m_live   = 1'b0;   // owner's request was seen on last edge
    logic [15:0] m_digits = 16'h0000;
    bit          m_ready  = 1'b0;
    int          m_win;
    logic [2:0]  m_others;

    function automatic int pick(input logic [2:0] r, input int start);
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (start + k) % 3;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [15:0] dsel(input int i);
        if (i == 0) return data0;
        if (i == 1) return data1;
        return data2;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_owner  = -1;
            m_age    = 0;
            m_ptr    = 0;
            m_live   = 1'b0;
            m_digits = 16'h0000;
            m_ready  = 1'b1;
        end else if (m_owner < 0) begin
            m_win = pick(req, m_ptr);
            if (m_win >= 0) begin
                m_owner = m_win;
                m_age   = 0;
                m_ptr   = (m_win + 1) % 3;
                m_live  = 1'b1;
            end
        end else begin
            if (m_live) m_digits = dsel(m_owner);
            if (m_age == HOLD - 1) begin
                m_others = req & ~(3'b001 << m_owner);
                m_win    = pick(m_others, (m_owner + 1) % 3);
                if (m_win >= 0) begin
                    m_owner = m_win;
                    m_age   = 0;
                    m_ptr   = (m_win + 1) % 3;
                    m_live  = 1'b1;
                end else if (req[m_owner]) begin
                    m_live = 1'b1;
                end else begin
                    m_owner = -1;
                    m_live  = 1'b0;
                end
            end else begin
                m_age  = m_age + 1;
                m_live = req[m_owner];
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        logic [2:0] eg;
        logic       eb;
        if (m_ready) begin
            eg = (m_owner < 0) ? 3'b000 : 3'(3'b001 << m_owner);
            eb = (m_owner < 0);
            vectors++;
            if ({grant, thousands, hundreds, tens, ones, blank} !==
                {eg, m_digits, eb}) begin
                miscompares++;
                $display("FAIL model t=%0t: got grant=%b digits=%h blank=%b, expected grant=%b digits=%h blank=%b",
                         $time, grant, {thousands, hundreds, tens, ones}, blank,
                         eg, m_digits, eb);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Directed literal checks
    // ------------------------------------------------------------------------
    task automatic check(input string name, input logic [15:0] got,
                         input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] digits();
        return {thousands, hundreds, tens, ones};
    endfunction

    initial begin
        logic [15:0] v;

        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("reset_grant",  16'(grant), 16'h0000);
        check("reset_blank",  16'(blank), 16'h0001);
        check("reset_digits", digits(),   16'h0000);

        // Single requester 1: grant one cycle later, digits one more cycle
        rst_n = 1'b1;
        req   = 3'b010;
        data1 = 16'h1234;
        tick();
        check("a_grant", 16'(grant), 16'(3'b010));
        check("a_blank", 16'(blank), 16'h0000);
        tick();
        check("a_digits", digits(), 16'h1234);
        req = 3'b000;
        repeat (6) tick();
        check("a_idle_grant",  16'(grant), 16'h0000);
        check("a_idle_blank",  16'(blank), 16'h0001);
        check("a_idle_digits", digits(),   16'h1234);

        // All three requesting: strict rotation, 4 cycles each
        apply_reset();
        req = 3'b111;
        for (int c = 0; c < 13; c++) begin
            logic [2:0] e;
            tick();
            e = 3'(3'b001 << ((c / 4) % 3));
            check("rr_grant", 16'(grant), 16'(e));
        end

        // One-cycle pulse: linger with frozen digits, then idle
        apply_reset();
        data0 = 16'h0042;
        req   = 3'b001;
        tick();
        check("pulse_grant0", 16'(grant), 16'(3'b001));
        req = 3'b000;
        tick();
        check("pulse_digits", digits(), 16'h0042);
        data0 = 16'h9999;
        for (int c = 0; c < 2; c++) begin
            tick();
            check("pulse_linger_grant",  16'(grant), 16'(3'b001));
            check("pulse_linger_digits", digits(),   16'h0042);
            check("pulse_linger_blank",  16'(blank), 16'h0000);
        end
        tick();
        check("pulse_idle_grant",  16'(grant), 16'h0000);
        check("pulse_idle_blank",  16'(blank), 16'h0001);
        check("pulse_idle_digits", digits(),   16'h0042);

        // Late contender: no switch until hold done, then gapless handover
        apply_reset();
        req = 3'b001;
        tick();
        check("late_g1", 16'(grant), 16'(3'b001));
        tick();
        req = 3'b101;
        tick();
        check("late_g3", 16'(grant), 16'(3'b001));
        tick();
        check("late_g4", 16'(grant), 16'(3'b001));
        tick();
        check("late_g5", 16'(grant), 16'(3'b100));

        // Reset during service of requester 2
        apply_reset();
        req   = 3'b100;
        data2 = 16'h5678;
        tick();
        check("rst_g", 16'(grant), 16'(3'b100));
        tick();
        check("rst_digits_pre", digits(), 16'h5678);
        rst_n = 1'b0;
        tick();
        check("rst_grant",  16'(grant), 16'h0000);
        check("rst_blank",  16'(blank), 16'h0001);
        check("rst_digits", digits(),   16'h0000);
        rst_n = 1'b1;
        req   = 3'b111;
        tick();
        check("rst_restart", 16'(grant), 16'(3'b001));

        // Continuous requester 0: live digit tracking past hold expiry
        apply_reset();
        req   = 3'b001;
        data0 = 16'h0000;
        tick();
        check("track_grant0", 16'(grant), 16'(3'b001));
        for (int k = 0; k < 12; k++) begin
            v     = 16'($urandom);
            data0 = v;
            tick();
            check("track_digits", digits(),   v);
            check("track_grant",  16'(grant), 16'(3'b001));
        end

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 0) data0 = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data1 = 16'($urandom);
            if ($urandom_range(0, 1) == 0) data2 = 16'($urandom);
            tick();
        end

        rst_n = 1'b1;
        req   = 3'b000;
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 The parameter list SHALL be: HOLD_CYCLES, default 200_000_000, minimum clock cycles a granted requester owns the display (2 s at 100 MHz; legal range 2..2^28).
REQ-002 The port list SHALL be, in order:
- clk  input  1  100 MHz clock, rising edge
- rst_n  input  1  synchronous, active-low reset
- req  input  3  per-requester display request, bit i = requester i
- data0  input  16  requester 0 BCD value {thousands,hundreds,tens,ones}
- data1  input  16  requester 1 BCD value, same packing
- data2  input  16  requester 2 BCD value, same packing
- grant  output  3  one-hot display owner, 3'b000 when idle
- thousands  output  4  digit to display mux
- hundreds  output  4  digit to display mux
- tens  output  4  digit to display mux
- ones  output  4  digit to display mux
- blank  output  1  high = no owner, display shall be blanked downstream
REQ-003 The block SHALL have one clock domain (clk); reset is synchronous and active-low (rst_n), sampled only on the rising clk edge.

Function
REQ-004 All outputs SHALL be registered; req and data are sampled at the rising clk edge.
REQ-005 FSM states SHALL be IDLE, SERVE and LINGER; the owner index g is held in a register.
REQ-006 Round-robin search SHALL begin at index ptr and wrap 2->0; the first asserted req bit wins.
REQ-007 In IDLE, when any req bit is high, the FSM SHALL enter SERVE, set g to the search winner, clear the hold counter, and assert grant[g] on the next cycle.
REQ-008 In SERVE, each cycle SHALL latch data_g nibbles into thousands/hundreds/tens/ones (live update, 1-cycle latency).
REQ-009 The hold counter SHALL increment every cycle in SERVE and LINGER and saturate at HOLD_CYCLES-1; hold_done = (counter == HOLD_CYCLES-1).
REQ-010 In SERVE with req[g] low and hold_done false, the FSM SHALL enter LINGER; the digits SHALL freeze at the last latched value and grant[g] SHALL stay asserted.
REQ-011 In LINGER, if req[g] reasserts before hold_done, the FSM SHALL return to SERVE without clearing the counter.
REQ-012 On hold_done (SERVE or LINGER), the search SHALL start at ptr = g+1 mod 3; if any other requester is pending, it SHALL become owner, the counter SHALL clear, and the FSM SHALL be in SERVE.
REQ-013 On hold_done with no other requester pending: if req[g] is high, stay in SERVE (counter stays saturated); otherwise go to IDLE.
REQ-014 A switch SHALL occur no earlier than HOLD_CYCLES cycles after grant rises; grant SHALL never have more than one bit set and SHALL change owner in a single cycle (no 000 gap between owners).
REQ-015 In IDLE, grant SHALL be 000, blank SHALL be 1, and the digits SHALL hold their last value; blank SHALL be 0 in SERVE and LINGER.
REQ-016 When req changes in the same cycle as hold_done, the value sampled that cycle SHALL decide the transition.
REQ-017 BCD nibbles SHALL pass unmodified; values above 9 are not checked.
REQ-018 ptr SHALL update only on a grant event (to g_new+1 mod 3).

Reset
REQ-019 While rst_n is low at a clk edge, the next state SHALL be: state IDLE, grant 000, blank 1, all digits 0, counter 0, g 0, ptr 0.
REQ-020 Reset asserted mid-SERVE or mid-LINGER SHALL abandon ownership immediately; arbitration SHALL restart from ptr 0 on the first cycle with rst_n high.

Verification (HOLD_CYCLES=4)
REQ-021 Reset, then req=010 with data1=16'h1234 -> grant=010 one cycle after req is sampled; the digits read 1,2,3,4 the cycle after that; blank=0.
REQ-022 req=111 from IDLE with ptr=0 -> grant sequence 001, 010, 100, 001, with each owner held exactly 4 cycles.
REQ-023 req=001 pulsed for 1 cycle, data0=16'h0042 -> grant=001 held 4 cycles, digits frozen at 0042 in LINGER, then IDLE with blank=1.
REQ-024 Owner 0 holding, req[2] raised at counter=1 -> no switch until counter=3; grant goes 001->100 with no 000 cycle in between.
REQ-025 rst_n low for 1 cycle during SERVE of requester 2 -> grant=000, digits 0, blank=1; with req=111 afterwards, requester 0 wins.
REQ-026 req=001 held continuously with data0 changing each cycle -> grant stays 001 indefinitely and the digits track data0 with 1-cycle latency.
